// File: rtl/adc_pkg.sv
// Shared constants and helpers for the VAUX6 sigma-delta ADC front end.
// Optional averaging is enabled by defining ADC_AVG4_EN.
package adc_pkg;

    localparam int DATA_W          = 16;
    localparam int CLK_DIV_DEF     = 4;
    localparam int LOCK_CYCLES_DEF = 64;
    localparam int RES_BITS_DEF    = 12;

    function automatic logic [DATA_W-1:0] left_just(
        input logic [DATA_W-1:0] v,
        input int                res
    );
        return v << (DATA_W - res);
    endfunction

endpackage

// File: rtl/adc_vaux6_if.sv
// Clock-generator bundle: lock flag, divided clock and sample strobe.
interface adc_vaux6_if;

    logic locked;
    logic clk_div;
    logic strobe;

    modport master (
        output locked,
        output clk_div,
        output strobe
    );

    modport slave (
        input locked,
        input clk_div,
        input strobe
    );

endinterface

// File: rtl/adc_clkgen.sv
// Lock counter, modulator clock divider and rising-edge sample strobe.
module adc_clkgen
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    adc_vaux6_if.master    ck
);

    localparam int HALF = CLK_DIV / 2;
    localparam int LW   = $clog2(LOCK_CYCLES + 1);
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          locked_q, locked_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          clk_q, clk_d;
    logic          strobe_q, strobe_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        div_cnt_d  = div_cnt_q;
        clk_d      = clk_q;
        strobe_d   = 1'b0;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            if (lock_cnt_d == LW'(LOCK_CYCLES)) begin
                locked_d = 1'b1;
            end
        end else if (div_cnt_q == DW'(HALF - 1)) begin
            div_cnt_d = '0;
            clk_d     = ~clk_q;
            // strobe coincides with the cycle clk_o reads 1 for the first time
            strobe_d  = ~clk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            div_cnt_q  <= '0;
            clk_q      <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            div_cnt_q  <= div_cnt_d;
            clk_q      <= clk_d;
            strobe_q   <= strobe_d;
        end
    end

    assign ck.locked  = locked_q;
    assign ck.clk_div = clk_q;
    assign ck.strobe  = strobe_q;

endmodule

// File: rtl/adc_vaux6.sv
// VAUX6 sigma-delta front end: synchronizers, sinc1 decimator, averager.
// Define ADC_AVG4_EN to output the mean of the last four results.
module adc_vaux6
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int RES_BITS    = RES_BITS_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              reset_i,
    output logic              locked_o,
    output logic              clk_o,
    input  logic              vaux6_p,
    input  logic              vaux6_n,
    output logic [DATA_W-1:0] data_o,
    output logic              eoc_o
);

    localparam int CW = RES_BITS + 1;

    adc_vaux6_if ck_if ();

    adc_clkgen #(
        .CLK_DIV     (CLK_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_clkgen (
        .clk   (CLK100MHZ),
        .rst_n (reset_i),
        .ck    (ck_if)
    );

    logic [1:0]          sync_p_q, sync_p_d;
    logic [1:0]          sync_n_q, sync_n_d;
    logic [CW-1:0]       ones_q, ones_d, ones_sum;
    logic [RES_BITS-1:0] samp_q, samp_d, result;
    logic [DATA_W-1:0]   data_q, data_d, new_data;
    logic                eoc_q, eoc_d;
    logic                sample, close;

    always_comb begin
        sync_p_d = {sync_p_q[0], vaux6_p};
        sync_n_d = {sync_n_q[0], vaux6_n};
        // equal legs are common-mode or invalid and count as zero
        sample   = sync_p_q[1] & ~sync_n_q[1];
        ones_sum = ones_q + CW'(sample);
        result   = ones_sum[RES_BITS] ? '1 : ones_sum[RES_BITS-1:0];
        close    = ck_if.strobe && (samp_q == '1);
    end

`ifdef ADC_AVG4_EN
    localparam int SW = RES_BITS + 2;

    logic [RES_BITS-1:0] hist_q [3];
    logic [RES_BITS-1:0] hist_d [3];
    logic [SW-1:0]       avg_sum;

    always_comb begin
        hist_d  = hist_q;
        avg_sum = SW'(result) + SW'(hist_q[0])
                + SW'(hist_q[1]) + SW'(hist_q[2]);
        new_data = left_just(DATA_W'(avg_sum[SW-1:2]), RES_BITS);
        if (close) begin
            hist_d[0] = result;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_i) begin
        if (!reset_i) begin
            hist_q <= '{default: '0};
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        new_data = left_just(DATA_W'(result), RES_BITS);
    end
`endif

    always_comb begin
        ones_d = ones_q;
        samp_d = samp_q;
        data_d = data_q;
        eoc_d  = 1'b0;
        if (close) begin
            ones_d = '0;
            samp_d = '0;
            data_d = new_data;
            eoc_d  = 1'b1;
        end else if (ck_if.strobe) begin
            ones_d = ones_sum;
            samp_d = samp_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_i) begin
        if (!reset_i) begin
            sync_p_q <= '0;
            sync_n_q <= '0;
            ones_q   <= '0;
            samp_q   <= '0;
            data_q   <= '0;
            eoc_q    <= 1'b0;
        end else begin
            sync_p_q <= sync_p_d;
            sync_n_q <= sync_n_d;
            ones_q   <= ones_d;
            samp_q   <= samp_d;
            data_q   <= data_d;
            eoc_q    <= eoc_d;
        end
    end

    assign locked_o = ck_if.locked;
    assign clk_o    = ck_if.clk_div;
    assign data_o   = data_q;
    assign eoc_o    = eoc_q;

endmodule

// File: tb/tb_adc_vaux6.sv
// Randomized bench for adc_vaux6 with a cycle-level behavioural model.
module tb_adc_vaux6;

    localparam int RB   = 4;
    localparam int OSR  = 16;
    localparam int LOCK = 64;
    localparam int DIV  = 4;
    // first clk_o rise: two cycles after the lock edge
    localparam int RISE = LOCK + DIV / 2;

    localparam int M_RAND = 0;
    localparam int M_FULL = 1;
    localparam int M_ZERO = 2;
    localparam int M_INV  = 3;
    localparam int M_MID  = 4;

`ifdef ADC_AVG4_EN
    localparam int FULL_1 = 32'h3000;
    localparam int FULL_3 = 32'hB000;
`else
    localparam int FULL_1 = 32'hF000;
    localparam int FULL_3 = 32'hF000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vp = 1'b0;
    logic        vn = 1'b0;
    logic        locked, clko, eoc;
    logic [15:0] data;

    int n_pass = 0;
    int n_total = 0;
    int mode = M_RAND;
    int cyc = 0;

    always #5 clk = ~clk;

    adc_vaux6 #(
        .CLK_DIV     (DIV),
        .LOCK_CYCLES (LOCK),
        .RES_BITS    (RB)
    ) dut (
        .CLK100MHZ (clk),
        .reset_i   (rst_n),
        .locked_o  (locked),
        .clk_o     (clko),
        .vaux6_p   (vp),
        .vaux6_n   (vn),
        .data_o    (data),
        .eoc_o     (eoc)
    );

    adc_vaux6_if mon ();
    assign mon.locked  = locked;
    assign mon.clk_div = clko;
    assign mon.strobe  = eoc;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // model state
    int          e = 0;
    logic [1:0]  in_hist [0:4095];
    int          m_ones = 0;
    int          m_n = 0;
    bit          m_close = 0;
    int          m_data = 0;
    int          m_hist [3];
    int          lock_edge = -1;
    int          eoc_data [$];
    longint      eoc_time [$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (mode)
                M_FULL: begin vp = 1'b1; vn = 1'b0; end
                M_ZERO: begin vp = 1'b0; vn = 1'b1; end
                M_INV:  begin vp = 1'b1; vn = 1'b1; end
                M_MID:  begin vp = 1'((cyc / DIV) % 2); vn = 1'b0; end
                default: begin
                    vp = 1'($urandom_range(0, 1));
                    vn = 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int exp_eoc, res, sum, s;
        if (!rst_n) begin
            e = 0;
            m_ones = 0;
            m_n = 0;
            m_close = 0;
            m_data = 0;
            m_hist[0] = 0;
            m_hist[1] = 0;
            m_hist[2] = 0;
            lock_edge = -1;
            check("rst_locked", int'(locked), 0);
            check("rst_clk", int'(clko), 0);
            check("rst_eoc", int'(eoc), 0);
            check("rst_data", int'(data), 0);
        end else begin
            e++;
            in_hist[e] = {vp, vn};
            exp_eoc = 0;
            if (m_close) begin
                m_close = 0;
                exp_eoc = 1;
                res = (m_ones > OSR - 1) ? OSR - 1 : m_ones;
`ifdef ADC_AVG4_EN
                sum = res + m_hist[0] + m_hist[1] + m_hist[2];
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = res;
                m_data = (sum / 4) << (16 - RB);
`else
                sum = res;
                m_data = sum << (16 - RB);
`endif
                m_ones = 0;
                m_n = 0;
            end
            if (e >= RISE && ((e - RISE) % DIV) == 0) begin
                s = int'(in_hist[e-2][1] & ~in_hist[e-2][0]);
                m_ones += s;
                m_n++;
                if (m_n == OSR) m_close = 1;
            end
            if (locked && lock_edge < 0) lock_edge = e;
            check("locked", int'(locked), int'(e >= LOCK));
            check("clk_o", int'(clko),
                  int'(e >= RISE && ((e - RISE) % DIV) < DIV / 2));
            check("eoc", int'(eoc), exp_eoc);
            check("data", int'(data), m_data);
            if (eoc) begin
                eoc_data.push_back(int'(data));
                eoc_time.push_back(longint'($time));
            end
        end
    end

    task automatic run(input int m, input int n);
        @(posedge clk);
        mode = m;
        eoc_data.delete();
        eoc_time.delete();
        repeat (n - 1) @(posedge clk);
    endtask

    function automatic int q_at(input int i);
        if (i >= 0 && i < eoc_data.size()) return eoc_data[i];
        return 32'hDEAD;
    endfunction

    function automatic int q_period();
        if (eoc_time.size() >= 2) return int'(eoc_time[1] - eoc_time[0]);
        return -1;
    endfunction

    initial begin
        rst_n = 1'b0;
        mode = M_RAND;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        run(M_FULL, RISE + 3 * OSR * DIV);
        check("lock_edge", lock_edge, LOCK);
        check("full_count", eoc_data.size(), 3);
        check("full_first", q_at(0), FULL_1);
        check("full_third", q_at(2), FULL_3);
        check("full_period", q_period(), OSR * DIV * 10);

        run(M_INV, 5 * OSR * DIV);
        check("inv_count", eoc_data.size(), 5);
        check("inv_last", q_at(4), 0);

        run(M_MID, 5 * OSR * DIV);
        check("mid_last", q_at(4), 32'h8000);
        check("mid_period", q_period(), OSR * DIV * 10);

        run(M_ZERO, 5 * OSR * DIV);
        check("zero_last", q_at(4), 0);

        run(M_RAND, 6 * OSR * DIV + 3 * DIV * 2 + 1);

        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_locked", int'(locked), 0);
        check("async_clk", int'(clko), 0);
        check("async_data", int'(data), 0);
        check("async_eoc", int'(eoc), 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        run(M_FULL, RISE + OSR * DIV + 8);
        check("relock_edge", lock_edge, LOCK);
        check("post_rst_count", eoc_data.size(), 1);
        check("post_rst_first", q_at(0), FULL_1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_vaux6.md
Name: adc_vaux6

Overview:
- Self-contained sigma-delta ADC front end for the VAUX6 auxiliary channel.
- Generates a divided modulator clock `clk_o` and a lock indicator from `CLK100MHZ`.
- Takes the external comparator bitstream on the `vaux6_p`/`vaux6_n` pair and decimates it with a counting (sinc1) filter.
- Publishes a 16-bit left-justified result on `data_o`, with a one-cycle end-of-conversion strobe on `eoc_o`.

Parameters:
- CLK_DIV, 4, divide ratio `CLK100MHZ`→`clk_o`; even, ≥2.
- LOCK_CYCLES, 64, `CLK100MHZ` cycles after reset release before `locked_o` asserts.
- RES_BITS, 12, result resolution (4..16); OSR = 2^RES_BITS samples per conversion.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- locked_o  out  1  high once the clock generator is stable.
- clk_o  out  1  modulator clock, `CLK100MHZ`/CLK_DIV, 50% duty.
- vaux6_p  in  1  comparator bitstream, positive leg (asynchronous).
- vaux6_n  in  1  comparator bitstream, negative leg (asynchronous).
- data_o  out  16  last conversion result, left-justified.
- eoc_o  out  1  one-cycle pulse when `data_o` updates.

Behaviour:
- Reset (`reset_i`=0, asynchronous assert, synchronous release): all registers clear. `locked_o`=0, `clk_o`=0, `data_o`=16'h0000, `eoc_o`=0.
- Lock counter:
  - Counts `CLK100MHZ` cycles from the first edge with `reset_i`=1.
  - `locked_o` rises on the edge where the count reaches LOCK_CYCLES, then stays high until reset.
- Clock output:
  - `clk_o` is held 0 while `locked_o`=0.
  - Once locked, it toggles every CLK_DIV/2 cycles; the first toggle is to 1.
  - An internal one-cycle sample strobe fires on every cycle in which `clk_o` goes 0→1.
- Input path:
  - Each leg passes through a two-flop synchronizer.
  - Sample bit = sync_p AND NOT sync_n, so p=n (invalid or common-mode) samples as 0.
- Decimator:
  - On each strobe, the sample bit is added to a (RES_BITS+1)-bit ones counter and the sample counter increments.
  - After OSR strobes, the window closes. The result is the ones count saturated to 2^RES_BITS−1 (all ones → max code).
  - On the cycle after the closing strobe:
    - `data_o` = {result, (16−RES_BITS) zeros}.
    - `eoc_o`=1 for exactly one cycle.
    - Both counters restart from 0, so there is no gap between windows.
- The first window starts at the first strobe after `locked_o` rises.
- `data_o` holds its value between conversions.
- Reset mid-conversion: the partial window is discarded, and all outputs return to their reset values immediately.
- Latency: `eoc_o` comes 1 cycle after the last strobe of a window. The synchronizer adds 2 cycles of input-to-sample delay.

Optional Feature:
- Macro ADC_AVG4_EN.
- Defined:
  - A 4-deep history of saturated results is kept.
  - `data_o` = (sum of last 4 results) >> 2, left-justified as above.
  - History entries start at 0 after reset, so the first 3 outputs ramp up.
  - `eoc_o` timing is unchanged.
- Undefined: `data_o` carries each raw result directly; the averaging logic is absent.

Decomposition:
- Package adc_pkg:
  - Output width constant DATA_W=16.
  - Default values for CLK_DIV, LOCK_CYCLES, RES_BITS.
  - A function for left-justifying a RES_BITS value into DATA_W.
- One natural sub-module, adc_clkgen, containing:
  - Lock counter → `locked_o`.
  - Divider → `clk_o`.
  - Sample strobe output.
- The top level holds the synchronizers, decimator and optional averager.

Test Plan:
- All scenarios use CLK_DIV=4, LOCK_CYCLES=64, RES_BITS=4 (OSR=16).
- Reset: hold `reset_i`=0 for 200 ns with inputs toggling → `locked_o`=0, `clk_o`=0, `data_o`=0x0000, `eoc_o`=0 throughout.
- Lock and clock: release reset → `locked_o` rises exactly 64 cycles (640 ns) later. `clk_o` then shows a 40 ns period, 20 ns high, first edge rising.
- Full scale: `vaux6_p`=1, `vaux6_n`=0 constant → first `eoc_o` pulse (1 cycle) with `data_o`=0xF000 (count 16 saturated to 15). Repeats every 640 ns.
- Zero and invalid inputs: `vaux6_p`=0/`vaux6_n`=1 → `data_o`=0x0000. `vaux6_p`=`vaux6_n`=1 → also 0x0000.
- Mid scale: alternate bits each `clk_o` period (8 ones per window) → `data_o`=0x8000, `eoc_o` period 640 ns. With ADC_AVG4_EN, successive outputs are 0x2000, 0x4000, 0x6000, 0x8000.
- Reset mid-conversion: assert `reset_i`=0 halfway through a window → outputs clear immediately. After release, `locked_o` re-waits 64 cycles, and the first new `eoc_o` reflects only post-reset samples.
